adc_sampler: RTL

Upstream capture stage for the audio spectrum analyzer: it drives the 8-bit serial audio ADC (ADC081S101-style, 16-SCLK frames) and delivers a paced stream of unsigned 8-bit samples with frame markers. It replaces the on-chip test-signal generator as the source for the FFT stage's `adc_data`/`trigger` inputs, and takes over the top-level `adc_cs`/`adc_clk`/`adc_dat` pins.

---
 rtl/adc_sampler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/adc_sampler.sv
// Serial ADC capture front end: paces 16-SCLK conversions on a fixed sample
// tick and delivers unsigned 8-bit samples with frame-start markers.
module adc_sampler #(
  parameter int CLK_DIV    = 3,
  parameter int SAMPLE_DIV = 750,
  parameter int FRAME_LEN  = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       adc_cs,
  output logic       adc_clk,
  input  logic       adc_dat,
  output logic [7:0] sample_data,
  output logic       sample_valid,
  output logic       frame_start,
  output logic       busy,
  output logic       overrun
);

  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = $clog2(FRAME_LEN);
  localparam logic [TW-1:0] TMR_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, SCLK_LO, SCLK_HI, DONE} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]    bit_q, bit_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          cs_q, cs_d;
  logic          sclk_q, sclk_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic          fs_q, fs_d;
  logic          ovr_q, ovr_d;
  logic          tick;
  logic          half_done;

  assign tick      = (tmr_q == '0);
  assign half_done = (div_q == DIV_LAST);

  // State register plus all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      data_q  <= 8'd128;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
      ovr_q   <= ovr_d;
    end
  end

  // The shift register needs no reset: it is fully rewritten before each use
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick && enable) state_d = SCLK_LO;
      SCLK_LO: if (half_done) state_d = SCLK_HI;
      SCLK_HI: if (half_done) state_d = (bit_q == 5'd16) ? DONE : SCLK_LO;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters and datapath; bit_q holds k for the whole SCLK high phase
  always_comb begin
    tmr_d   = (tmr_q == TMR_LAST) ? '0 : tmr_q + 1'b1;
    div_d   = (state_q == IDLE || state_q == DONE || half_done) ? '0 : div_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    ovr_d   = ovr_q | (tick && state_q != IDLE);
    if (state_q == IDLE)
      bit_d = '0;
    else if (state_q == SCLK_LO && half_done)
      bit_d = bit_q + 5'd1;
    if (state_q == SCLK_HI && div_q == '0 && bit_q >= 5'd4 && bit_q <= 5'd11)
      shift_d = {shift_q[6:0], adc_dat};
    if (state_q == DONE)
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    else if (state_q == IDLE && !enable)
      idx_d = '0;
  end

  // Output decode, looking one state ahead so the pins come straight from flops
  always_comb begin
    cs_d    = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    sclk_d  = (state_d != SCLK_LO);
    valid_d = (state_q == DONE);
    fs_d    = (state_q == DONE) && (idx_q == '0);
    data_d  = (state_q == DONE) ? shift_q : data_q;
  end

  assign adc_cs       = cs_q;
  assign adc_clk      = sclk_q;
  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign frame_start  = fs_q;
  assign busy         = busy_q;
  assign overrun      = ovr_q;

endmodule
